// File: rtl/sd_cmd_host.sv
// SD card host-side CMD line engine: serialises one 48-bit command frame with
// CRC7, then optionally collects a 48- or 136-bit response from the card.
//
// Request handshake: new_command is a level request that is only examined in
// IDLE. The command is taken on the clock edge where the block is IDLE and
// new_command=1. busy stays high from SEND through RECEIVE, and new_command is
// ignored during that time. cmd_complete is a one-clock completion strobe.
module sd_cmd_host #(
    parameter int NCR_MAX = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         new_command,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_argument,
    input  logic         timeout_enable,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_pin_oe,
    output logic [135:0] response,
    output logic         response_valid,
    output logic         busy,
    output logic         cmd_complete,
    output logic         timeout_error,
    output logic [2:0]   state_dbg
);

    localparam int WAIT_W = $clog2(NCR_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_RECEIVE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [47:0]        tx_shift;
    logic [5:0]         idx_q;
    logic [7:0]         bit_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [6:0]         crc;
    logic               long_resp;
    logic               no_resp;
    logic               send_last;
    logic               rx_last;
    logic               wait_expired;

    // CRC7 (x^7 + x^3 + 1), zero seed, MSB-first over the 40 header bits.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // CRC of the command being presented, so the full frame loads on accept.
    always_comb begin
        crc = crc7({2'b01, cmd_index, cmd_argument});
    end

    assign long_resp = (idx_q == 6'd2) || (idx_q == 6'd9) || (idx_q == 6'd10);
    assign no_resp   = (idx_q == 6'd0);
    assign send_last = (bit_cnt == 8'd47);
    // bit_cnt holds the number of response bits already captured.
    assign rx_last   = (bit_cnt == (long_resp ? 8'd135 : 8'd47));
    // WAIT_RESP lasts NCR_MAX-1 clocks, so DONE lands NCR_MAX clocks after the end bit.
    assign wait_expired = timeout_enable && (wait_cnt >= WAIT_W'(NCR_MAX - 2));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (new_command) state_nx = ST_SEND;
            ST_SEND:      if (send_last) state_nx = no_resp ? ST_DONE : ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (!cmd_pin_in)       state_nx = ST_RECEIVE;
                else if (wait_expired) state_nx = ST_DONE;
            end
            ST_RECEIVE:   if (rx_last) state_nx = ST_DONE;
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; the line idles high and released.
    always_comb begin
        cmd_pin_oe   = (state == ST_SEND);
        cmd_pin_out  = (state == ST_SEND) ? tx_shift[47] : 1'b1;
        busy         = (state == ST_SEND) || (state == ST_WAIT_RESP) || (state == ST_RECEIVE);
        cmd_complete = (state == ST_DONE);
        state_dbg    = state;
    end

    // Datapath: frame shifter, counters, response capture and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_shift       <= '1;
            idx_q          <= '0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            response       <= '0;
            response_valid <= 1'b0;
            timeout_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_command) begin
                        idx_q          <= cmd_index;
                        tx_shift       <= {2'b01, cmd_index, cmd_argument, crc, 1'b1};
                        bit_cnt        <= '0;
                        wait_cnt       <= '0;
                        response       <= '0;
                        response_valid <= 1'b0;
                        timeout_error  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    tx_shift <= {tx_shift[46:0], 1'b1};
                    bit_cnt  <= send_last ? 8'd0 : bit_cnt + 8'd1;
                end
                ST_WAIT_RESP: begin
                    if (!cmd_pin_in) begin
                        // Start bit becomes the first captured response bit.
                        response <= {response[134:0], 1'b0};
                        bit_cnt  <= 8'd1;
                    end else if (wait_expired) begin
                        timeout_error <= 1'b1;
                    end else if (wait_cnt != WAIT_W'(NCR_MAX - 1)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    response <= {response[134:0], cmd_pin_in};
                    if (rx_last) begin
                        response_valid <= 1'b1;
                        bit_cnt        <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    bit_cnt  <= '0;
                    wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_host.sv
// Testbench for sd_cmd_host: drives commands, plays the card side of the CMD
// line, and scores captured frames and responses against expected queues.
module tb_sd_cmd_host;

    localparam int NCR_MAX = 64;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         new_command = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_argument = '0;
    logic         timeout_enable = 1'b1;
    logic         cmd_pin_in = 1'b1;
    logic         cmd_pin_out;
    logic         cmd_pin_oe;
    logic [135:0] response;
    logic         response_valid;
    logic         busy;
    logic         cmd_complete;
    logic         timeout_error;
    logic [2:0]   state_dbg;

    always #5 clock = ~clock;

    sd_cmd_host #(.NCR_MAX(NCR_MAX)) dut (
        .clock          (clock),
        .reset          (reset),
        .new_command    (new_command),
        .cmd_index      (cmd_index),
        .cmd_argument   (cmd_argument),
        .timeout_enable (timeout_enable),
        .cmd_pin_in     (cmd_pin_in),
        .cmd_pin_out    (cmd_pin_out),
        .cmd_pin_oe     (cmd_pin_oe),
        .response       (response),
        .response_valid (response_valid),
        .busy           (busy),
        .cmd_complete   (cmd_complete),
        .timeout_error  (timeout_error),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [135:0] exp_frame_q[$];
    logic [135:0] exp_resp_q[$];

    task automatic check_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame built by polynomial long division of header * x^7.
    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [46:0] rem;
        rem = {2'b01, idx, arg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        return {2'b01, idx, arg, rem[6:0], 1'b1};
    endfunction

    function automatic int resp_len(input logic [5:0] idx);
        if (idx == 6'd0) return 0;
        if (idx == 6'd2 || idx == 6'd9 || idx == 6'd10) return 136;
        return 48;
    endfunction

    function automatic logic [135:0] rand_resp(input int len);
        logic [135:0] r;
        r = '0;
        for (int k = 0; k < 136; k++)
            if (k < len) r[k] = 1'($urandom_range(0, 1));
        r[len-1] = 1'b0;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Present a command and let it be accepted on the next edge.
    task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [47:0] exp_frame, input bit hold);
        exp_frame_q.push_back({88'b0, exp_frame});
        cmd_index    = idx;
        cmd_argument = arg;
        new_command  = 1'b1;
        tick();
        if (!hold) new_command = 1'b0;
    endtask

    // Sample the 48 serial bits; optionally pulse new_command at bit number pulse_at.
    task automatic capture_frame(input string tag, input int pulse_at);
        logic [47:0] got;
        logic        oe_ok;
        oe_ok = 1'b1;
        for (int i = 47; i >= 0; i--) begin
            if (cmd_pin_oe !== 1'b1) oe_ok = 1'b0;
            got[i] = cmd_pin_out;
            if (pulse_at >= 0) begin
                if (47 - i == pulse_at) begin
                    new_command  = 1'b1;
                    cmd_index    = 6'd0;
                    cmd_argument = ~cmd_argument;
                end else begin
                    new_command = 1'b0;
                end
            end
            tick();
        end
        if (pulse_at >= 0) new_command = 1'b0;
        check_val({tag, "_oe_during_send"}, oe_ok, 1'b1);
        if (exp_frame_q.size() == 0) check_val({tag, "_frame_q_empty"}, 1'b1, 1'b0);
        else check_val({tag, "_frame"}, {88'b0, got}, exp_frame_q.pop_front());
        check_val({tag, "_oe_released"}, cmd_pin_oe, 1'b0);
        check_val({tag, "_line_high"}, cmd_pin_out, 1'b1);
    endtask

    // Card side: start bit appears 'delay' clocks after the end bit.
    task automatic card_send(input logic [135:0] frame, input int len, input int delay);
        exp_resp_q.push_back(frame);
        repeat (delay - 1) tick();
        for (int k = len - 1; k >= 0; k--) begin
            cmd_pin_in = frame[k];
            tick();
        end
        cmd_pin_in = 1'b1;
    endtask

    // Expect to be sitting in the completion cycle.
    task automatic check_done(input string tag, input logic exp_valid, input logic exp_to);
        check_val({tag, "_complete"}, cmd_complete, 1'b1);
        check_val({tag, "_busy_done"}, busy, 1'b0);
        check_val({tag, "_valid"}, response_valid, exp_valid);
        check_val({tag, "_timeout"}, timeout_error, exp_to);
        if (exp_valid) begin
            if (exp_resp_q.size() == 0) check_val({tag, "_resp_q_empty"}, 1'b1, 1'b0);
            else check_val({tag, "_resp"}, response, exp_resp_q.pop_front());
        end else begin
            check_val({tag, "_resp_zero"}, response, 136'b0);
        end
        tick();
        check_val({tag, "_complete_one_pulse"}, cmd_complete, 1'b0);
        check_val({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    // Full command with a card response of the right length.
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input int delay);
        int           len;
        logic [135:0] r;
        len = resp_len(idx);
        issue_cmd(idx, arg, make_frame(idx, arg), 1'b0);
        capture_frame(tag, -1);
        if (len == 0) begin
            check_done(tag, 1'b0, 1'b0);
        end else begin
            r = rand_resp(len);
            card_send(r, len, delay);
            check_done(tag, 1'b1, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int   n;
        logic seen;
        logic lost;
        logic [5:0] idx;

        // Reset state
        #3 reset = 1'b0;
        tick();
        tick();
        check_val("rst_oe", cmd_pin_oe, 1'b0);
        check_val("rst_line", cmd_pin_out, 1'b1);
        check_val("rst_resp", response, 136'b0);
        check_val("rst_valid", response_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_complete", cmd_complete, 1'b0);
        check_val("rst_timeout", timeout_error, 1'b0);
        check_val("rst_state", state_dbg, 3'd0);
        reset = 1'b1;
        tick();

        // CMD0: known frame, no response
        issue_cmd(6'd0, 32'h0, 48'h400000000095, 1'b0);
        check_val("cmd0_busy", busy, 1'b1);
        capture_frame("cmd0", -1);
        check_done("cmd0", 1'b0, 1'b0);

        // CMD41 with fixed card response 10 clocks after the end bit
        issue_cmd(6'd41, 32'hFA74CD23, make_frame(6'd41, 32'hFA74CD23), 1'b0);
        capture_frame("cmd41", -1);
        card_send({88'b0, 1'b0, 1'b0, 6'd63, 32'h3BA692AF, 7'h7F, 1'b1}, 48, 10);
        check_done("cmd41", 1'b1, 1'b0);

        // CMD2 with a long response
        run_cmd("cmd2", 6'd2, $urandom, $urandom_range(1, 20));

        // Random commands, both response lengths
        for (int t = 0; t < 6; t++) begin
            idx = 6'($urandom_range(1, 63));
            run_cmd("rand", idx, $urandom, $urandom_range(1, 20));
        end

        // Latest legal start bit with timeout enabled
        run_cmd("late_start", 6'd9, $urandom, NCR_MAX - 1);

        // Timeout: line stays high
        timeout_enable = 1'b1;
        issue_cmd(6'd17, 32'h1234, make_frame(6'd17, 32'h1234), 1'b0);
        capture_frame("to", -1);
        n = 0;
        while (cmd_complete !== 1'b1 && n < 4 * NCR_MAX) begin
            tick();
            n++;
        end
        check_val("to_latency", 136'(n + 1), 136'(NCR_MAX));
        check_done("to", 1'b0, 1'b1);

        // Timeout disabled: stays busy, then a late response still lands
        timeout_enable = 1'b0;
        issue_cmd(6'd13, 32'hA5A5_0001, make_frame(6'd13, 32'hA5A5_0001), 1'b0);
        capture_frame("noto", -1);
        seen = 1'b0;
        lost = 1'b0;
        repeat (3 * NCR_MAX) begin
            if (cmd_complete) seen = 1'b1;
            if (!busy) lost = 1'b1;
            tick();
        end
        check_val("noto_no_complete", seen, 1'b0);
        check_val("noto_stays_busy", lost, 1'b0);
        card_send(rand_resp(48), 48, 1);
        check_done("noto", 1'b1, 1'b0);
        timeout_enable = 1'b1;

        // new_command pulsed mid-SEND is ignored
        issue_cmd(6'd17, 32'hDEAD_BEEF, make_frame(6'd17, 32'hDEAD_BEEF), 1'b0);
        capture_frame("busy_pulse", 20);
        card_send(rand_resp(48), 48, 3);
        check_done("busy_pulse", 1'b1, 1'b0);
        check_val("busy_pulse_no_restart", state_dbg, 3'd0);

        // new_command held high: ignored while busy, restarts on return to IDLE
        issue_cmd(6'd0, 32'h0, 48'h400000000095, 1'b1);
        capture_frame("hold1", -1);
        check_done("hold1", 1'b0, 1'b0);
        issue_cmd(6'd0, 32'h0, 48'h400000000095, 1'b0);
        capture_frame("hold2", -1);
        check_done("hold2", 1'b0, 1'b0);

        // Reset in the middle of SEND
        issue_cmd(6'd8, 32'h0000_01AA, make_frame(6'd8, 32'h0000_01AA), 1'b0);
        void'(exp_frame_q.pop_front());
        repeat (10) tick();
        check_val("midrst_oe_before", cmd_pin_oe, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_val("midrst_oe", cmd_pin_oe, 1'b0);
        check_val("midrst_line", cmd_pin_out, 1'b1);
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_complete", cmd_complete, 1'b0);
        check_val("midrst_valid", response_valid, 1'b0);
        check_val("midrst_timeout", timeout_error, 1'b0);
        check_val("midrst_resp", response, 136'b0);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            if (cmd_complete || cmd_pin_oe) seen = 1'b1;
            tick();
        end
        check_val("midrst_quiet", seen, 1'b0);

        // Afterwards a normal command still works
        run_cmd("post_rst", 6'd55, $urandom, 5);

        check_val("frame_q_drained", 136'(exp_frame_q.size()), 136'd0);
        check_val("resp_q_drained", 136'(exp_resp_q.size()), 136'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
